// File: rtl/race_display_ctrl_pkg.sv
// Shared encodings and constants for the race sequencing / display controller.
// Time words are packed BCD {M, S1, S0, t1, t0}, one nibble per digit, t0 in the LSBs.
package race_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_FINISHED = 2'd3
  } state_t;

  localparam logic [19:0] BCD_MAX    = 20'h95999;
  localparam logic [19:0] BCD_ZERO   = 20'h00000;
  localparam logic [3:0]  DIGIT_OFF  = 4'hF;
  localparam int          NUM_DIGITS = 5;
  localparam int          DIGIT_W    = 4;

  // Digit slice positions: digit idx occupies [idx*DIGIT_W +: DIGIT_W]
  localparam int D0_LSB = 0;
  localparam int D1_LSB = 4;
  localparam int D2_LSB = 8;
  localparam int D3_LSB = 12;
  localparam int D4_LSB = 16;

  function automatic logic [3:0] get_digit(input logic [19:0] word, input int idx);
    return word[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/race_display_ctrl_blink.sv
// Blink phase generator: phase toggles every BLINK_COUNT cycles and restarts
// visible (phase 0, count 0) whenever sync_clr is asserted.
module blink_gen #(
  parameter int BLINK_COUNT = 6_250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_clr,
  output logic phase
);

  localparam int CW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_COUNT - 1);

  logic [CW-1:0] count_reg;
  logic          phase_reg;

  always_ff @(posedge clk) begin
    if (rst || sync_clr) begin
      count_reg <= '0;
      phase_reg <= 1'b0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign phase = phase_reg;

endmodule

// File: rtl/race_display_ctrl.sv
// Race sequencing controller: turns button/gate pulses into counter commands,
// keeps last result and best time, and selects/blinks the five display digits.
module race_display_ctrl
  import race_display_ctrl_pkg::*;
#(
  parameter int          BLINK_COUNT = 6_250_000,
  parameter logic [19:0] MIN_RUN_BCD = 20'h00100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm_p,
  input  logic        clr_p,
  input  logic        start_p,
  input  logic        finish_p,
  input  logic [19:0] live_bcd,
  input  logic        cnt_max,
  output logic        cnt_clear,
  output logic        cnt_run,
  output logic [3:0]  bcd_out_d4,
  output logic [3:0]  bcd_out_d3,
  output logic [3:0]  bcd_out_d2,
  output logic [3:0]  bcd_out_d1,
  output logic [3:0]  bcd_out_d0,
  output logic        new_record,
  output logic        dnf,
  output logic [1:0]  state_out
);

  state_t      state_reg, state_next;
  logic [19:0] best_reg;
  logic        best_valid_reg;
  logic [19:0] result_reg;
  logic        new_record_reg;
  logic        dnf_reg;
  logic        finish_ok;
  logic        blink_phase;
  logic        blink_en;
  logic [19:0] disp_src;

  // Packed BCD compares correctly as plain unsigned binary
  assign finish_ok = finish_p && (live_bcd >= MIN_RUN_BCD);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (!clr_p && arm_p) state_next = ST_ARMED;
      ST_ARMED:    if (clr_p) state_next = ST_IDLE;
                   else if (start_p) state_next = ST_RUNNING;
      ST_RUNNING:  if (clr_p) state_next = ST_IDLE;
                   else if (cnt_max || finish_ok) state_next = ST_FINISHED;
      ST_FINISHED: if (clr_p) state_next = ST_IDLE;
                   else if (arm_p) state_next = ST_ARMED;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      best_reg       <= BCD_MAX;
      best_valid_reg <= 1'b0;
      result_reg     <= BCD_ZERO;
      new_record_reg <= 1'b0;
      dnf_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (clr_p) begin
            best_valid_reg <= 1'b0;
            best_reg       <= BCD_MAX;
          end else if (arm_p) begin
            new_record_reg <= 1'b0;
            dnf_reg        <= 1'b0;
          end
        end
        ST_RUNNING: begin
          if (clr_p) begin
            // abort: result and best untouched
          end else if (cnt_max) begin
            result_reg <= BCD_MAX;
            dnf_reg    <= 1'b1;
          end else if (finish_ok) begin
            result_reg <= live_bcd;
            if (!best_valid_reg || (live_bcd < best_reg)) begin
              best_reg       <= live_bcd;
              best_valid_reg <= 1'b1;
              new_record_reg <= 1'b1;
            end
          end
        end
        ST_FINISHED: begin
          if (!clr_p && arm_p) begin
            new_record_reg <= 1'b0;
            dnf_reg        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Clearing on the transition edge makes every new state start visible
  blink_gen #(
    .BLINK_COUNT(BLINK_COUNT)
  ) u_blink (
    .clk      (clk),
    .rst      (rst),
    .sync_clr (state_next != state_reg),
    .phase    (blink_phase)
  );

  always_comb begin
    disp_src = BCD_ZERO;
    case (state_reg)
      ST_IDLE:     disp_src = best_valid_reg ? best_reg : BCD_ZERO;
      ST_ARMED:    disp_src = BCD_ZERO;
      ST_RUNNING:  disp_src = live_bcd;
      ST_FINISHED: disp_src = result_reg;
      default:     disp_src = BCD_ZERO;
    endcase
  end

  assign blink_en = (state_reg == ST_ARMED) ||
                    ((state_reg == ST_FINISHED) && (new_record_reg || dnf_reg));

  logic [3:0] digit_vec [NUM_DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_vec[gi] = (blink_en && blink_phase) ? DIGIT_OFF : get_digit(disp_src, gi);
    end
  endgenerate

  assign bcd_out_d4 = digit_vec[4];
  assign bcd_out_d3 = digit_vec[3];
  assign bcd_out_d2 = digit_vec[2];
  assign bcd_out_d1 = digit_vec[1];
  assign bcd_out_d0 = digit_vec[0];

  assign cnt_clear  = (state_reg == ST_IDLE) || (state_reg == ST_ARMED);
  assign cnt_run    = (state_reg == ST_RUNNING);
  assign new_record = new_record_reg;
  assign dnf        = dnf_reg;
  assign state_out  = state_reg;

endmodule

// File: tb/tb_race_display_ctrl.sv
// Scoreboard bench for race_display_ctrl: a driver issues directed and random
// pulses, a reference model queues the expected post-edge outputs, a monitor compares.
module tb_race_display_ctrl;

  localparam int          BC      = 4;
  localparam logic [19:0] MIN_RUN = 20'h00100;
  localparam logic [19:0] MAXT    = 20'h95999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm_p = 1'b0, clr_p = 1'b0, start_p = 1'b0, finish_p = 1'b0;
  logic [19:0] live_bcd = 20'h0;
  logic        cnt_max = 1'b0;
  logic        cnt_clear, cnt_run, new_record, dnf;
  logic [3:0]  d4, d3, d2, d1, d0;
  logic [1:0]  state_out;

  race_display_ctrl #(.BLINK_COUNT(BC), .MIN_RUN_BCD(MIN_RUN)) dut (
    .clk(clk), .rst(rst), .arm_p(arm_p), .clr_p(clr_p), .start_p(start_p),
    .finish_p(finish_p), .live_bcd(live_bcd), .cnt_max(cnt_max),
    .cnt_clear(cnt_clear), .cnt_run(cnt_run),
    .bcd_out_d4(d4), .bcd_out_d3(d3), .bcd_out_d2(d2), .bcd_out_d1(d1), .bcd_out_d0(d0),
    .new_record(new_record), .dnf(dnf), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic        clr;
    logic        run;
    logic [19:0] dig;
    logic        nr;
    logic        dnf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn = 0;

  // Reference model: stopwatch rules with an "age in state" counter for blinking
  int          m_st = 0;
  logic [19:0] m_best = MAXT, m_res = 20'h0;
  bit          m_bv = 0, m_nr = 0, m_dnf = 0;
  int          m_age = 0;

  task automatic model_step(input bit r, a, c, s, f, m, input logic [19:0] live);
    int ns;
    if (r) begin
      m_st = 0; m_bv = 0; m_best = MAXT; m_res = 20'h0;
      m_nr = 0; m_dnf = 0; m_age = 0;
      return;
    end
    ns = m_st;
    if (m_st == 0) begin
      if (c) begin m_bv = 0; m_best = MAXT; end
      else if (a) begin ns = 1; m_nr = 0; m_dnf = 0; end
    end else if (m_st == 1) begin
      if (c) ns = 0; else if (s) ns = 2;
    end else if (m_st == 2) begin
      if (c) ns = 0;
      else if (m) begin ns = 3; m_res = MAXT; m_dnf = 1; end
      else if (f && live >= MIN_RUN) begin
        ns = 3; m_res = live;
        if (!m_bv || live < m_best) begin m_best = live; m_bv = 1; m_nr = 1; end
      end
    end else begin
      if (c) ns = 0;
      else if (a) begin ns = 1; m_nr = 0; m_dnf = 0; end
    end
    m_age = (ns != m_st) ? 0 : m_age + 1;
    m_st  = ns;
  endtask

  function automatic exp_t model_out(input logic [19:0] live);
    exp_t e;
    logic [19:0] src;
    bit blank;
    case (m_st)
      0:       src = m_bv ? m_best : 20'h0;
      1:       src = 20'h0;
      2:       src = live;
      default: src = m_res;
    endcase
    blank = ((m_st == 1) || (m_st == 3 && (m_nr || m_dnf))) && (((m_age / BC) % 2) == 1);
    e.st  = 2'(m_st);
    e.clr = (m_st <= 1);
    e.run = (m_st == 2);
    e.dig = blank ? 20'hFFFFF : src;
    e.nr  = m_nr;
    e.dnf = m_dnf;
    return e;
  endfunction

  task automatic cyc(input bit r, a, c, s, f, m, input logic [19:0] live);
    @(negedge clk);
    rst = r; arm_p = a; clr_p = c; start_p = s; finish_p = f; cnt_max = m; live_bcd = live;
    model_step(r, a, c, s, f, m, live);
    sb_q.push_back(model_out(live));
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic [19:0] live);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, live);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s txn %0d: got %h expected %h", name, n_txn, act, exp);
    end
  endtask

  // Monitor: every cycle's post-edge outputs are the DUT's presented response
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_txn++;
        check("state", 32'(state_out), 32'(e.st));
        check("cnt_cmd", 32'({cnt_clear, cnt_run}), 32'({e.clr, e.run}));
        check("digits", 32'({d4, d3, d2, d1, d0}), 32'(e.dig));
        check("flags", 32'({new_record, dnf}), 32'({e.nr, e.dnf}));
        $display("txn %0d st=%0d clr=%0b run=%0b digits=%h nr=%0b dnf=%0b",
                 n_txn, state_out, cnt_clear, cnt_run, {d4, d3, d2, d1, d0}, new_record, dnf);
      end
    end
  end

  function automatic logic [19:0] rand_bcd();
    logic [3:0] m;
    m = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 9)) : 4'h0;
    return {m, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  initial begin
    logic [19:0] lv;
    int sel;
    // Reset
    cyc(1, 0, 0, 0, 0, 0, 20'h0);
    cyc(1, 0, 0, 0, 0, 0, 20'h0);
    idle(2, 20'h0);
    // Arm, start, live tracking
    cyc(0, 1, 0, 0, 0, 0, 20'h0);
    idle(5, 20'h0);
    cyc(0, 0, 0, 1, 0, 0, 20'h00000);
    for (int i = 1; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 20'(i * 16'h0011));
    // Finish too early, then at the boundary below minimum, then valid finish
    cyc(0, 0, 0, 0, 1, 0, 20'h00050);
    cyc(0, 0, 0, 0, 1, 0, 20'h00099);
    cyc(0, 0, 0, 0, 1, 0, 20'h01234);
    idle(12, 20'h01240);
    // Equal time is not a record
    cyc(0, 1, 0, 0, 0, 0, 20'h0);
    cyc(0, 0, 0, 1, 0, 0, 20'h0);
    cyc(0, 0, 0, 0, 1, 0, 20'h01234);
    idle(6, 20'h0);
    // Better time, accepted exactly at the minimum path covered by random later
    cyc(0, 1, 0, 0, 0, 0, 20'h0);
    cyc(0, 0, 0, 1, 0, 0, 20'h0);
    cyc(0, 0, 0, 0, 1, 0, 20'h01199);
    idle(4, 20'h0);
    // Overflow wins over finish in the same cycle
    cyc(0, 1, 0, 0, 0, 0, 20'h0);
    cyc(0, 0, 0, 1, 0, 0, 20'h0);
    cyc(0, 0, 0, 0, 1, 1, 20'h00500);
    idle(10, 20'h0);
    // Abort wins over finish; then clear best from IDLE
    cyc(0, 1, 0, 0, 0, 0, 20'h0);
    cyc(0, 0, 0, 1, 0, 0, 20'h0);
    cyc(0, 0, 1, 0, 1, 0, 20'h00300);
    idle(2, 20'h0);
    cyc(0, 0, 1, 0, 0, 0, 20'h0);
    idle(2, 20'h0);
    // Minimum boundary accepted, then reset mid-run, then blink restart on ARMED
    cyc(0, 1, 0, 0, 0, 0, 20'h0);
    cyc(0, 0, 0, 1, 0, 0, 20'h0);
    cyc(0, 0, 0, 0, 1, 0, 20'h00100);
    cyc(0, 1, 0, 0, 0, 0, 20'h0);
    cyc(0, 0, 0, 1, 0, 0, 20'h0);
    idle(3, 20'h00777);
    cyc(1, 0, 0, 0, 0, 0, 20'h00777);
    idle(3, 20'h0);
    cyc(0, 1, 0, 0, 0, 0, 20'h0);
    idle(11, 20'h0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      lv  = (sel == 0) ? 20'h00099 : (sel == 1) ? 20'h00100 :
            (sel == 2) ? m_best : rand_bcd();
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 59) == 0), lv);
    end
    idle(2, 20'h0);
    @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/race_display_ctrl.md
Name: race_display_ctrl

Overview:
- Race sequencing controller for the stopwatch. Turns arm/reset button pulses and start/finish sensor pulses into clear/run commands for the M:SS:tt BCD counter.
- Holds the last result and the best time.
- Drives the five BCD digit inputs of the 5-digit display multiplexer, choosing live, frozen or best time, with whole-display blinking.
- Digit code 4'hF means "digit off" downstream.

Parameters:
- BLINK_COUNT, 6_250_000, clk cycles per blink half-period (0.25 s at 25 MHz).
- MIN_RUN_BCD, 20'h00100, packed BCD {M,S1,S0,t1,t0}. Minimum elapsed time before a finish pulse is accepted (1.00 s).

Ports:
- clk  in  1  system clock, 25 MHz.
- rst  in  1  synchronous, active-high reset.
- arm_p  in  1  one-cycle pulse, arm button (debounced upstream).
- clr_p  in  1  one-cycle pulse, reset/abort button (debounced upstream).
- start_p  in  1  one-cycle pulse, start-gate sensor.
- finish_p  in  1  one-cycle pulse, finish-gate sensor.
- live_bcd  in  20  counter value {M,S1,S0,t1,t0}, valid BCD.
- cnt_max  in  1  counter is at 9:59.99 (saturated).
- cnt_clear  out  1  counter synchronous clear.
- cnt_run  out  1  counter count enable.
- bcd_out_d4..bcd_out_d0  out  4 each  digits to the display mux (d4=M ... d0=t units).
- new_record  out  1  last result set a new best.
- dnf  out  1  last run ended by overflow.
- state_out  out  2  current state encoding.

Behaviour:
States (2-bit): IDLE=0, ARMED=1, RUNNING=2, FINISHED=3.

Reset (rst=1 at an edge):
- state IDLE, best_valid=0, best=20'h95999, result=0, new_record=0, dnf=0.
- Blink counter 0, blink_phase 0 (visible).
- Outputs during/after reset: cnt_clear=1, cnt_run=0, digits 0:00.00.
- rst mid-run abandons the run. The best time is lost.

Transition priority within one cycle: clr_p > cnt_max > finish_p > start_p/arm_p.
- IDLE:
  - arm_p -> ARMED; clear new_record and dnf.
  - clr_p in IDLE -> best_valid=0, best=20'h95999; stay in IDLE.
- ARMED:
  - start_p -> RUNNING.
  - clr_p -> IDLE.
  - finish_p is ignored.
- RUNNING:
  - clr_p -> IDLE; result unchanged.
  - cnt_max=1 -> FINISHED; result=20'h95999, dnf=1; best not updated.
  - finish_p with live_bcd >= MIN_RUN_BCD -> FINISHED; result=live_bcd sampled at that edge.
    - If !best_valid or live_bcd < best: best=live_bcd, best_valid=1, new_record=1.
    - Equal to best is not a record.
  - finish_p below MIN_RUN_BCD is ignored.
  - start_p is ignored.
- FINISHED:
  - arm_p -> ARMED; clear new_record and dnf.
  - clr_p -> IDLE; flags kept.

Counter commands (Moore, decoded from the registered state):
- cnt_clear=1 in IDLE and ARMED, else 0.
- cnt_run=1 only in RUNNING.
- Latency: a pulse sampled at edge k gives the new state and new cnt_run/cnt_clear immediately after edge k.

Comparison rule: packed valid BCD compared as a 20-bit unsigned value is order-correct. No binary conversion.

Display source (combinational from registers):
- IDLE: best if best_valid, else 0:00.00.
- ARMED: 0:00.00.
- RUNNING: live_bcd (zero added latency).
- FINISHED: result.

Blink:
- blink_en = ARMED or (FINISHED and (new_record or dnf)).
- When blink_en and blink_phase=1, all five digits = 4'hF.
- blink_phase toggles every BLINK_COUNT cycles.
- Counter and phase clear synchronously on every state change, so each new state starts visible for a full half-period.

Decomposition:
- Shared package/header:
  - State encodings.
  - BCD_MAX=20'h95999.
  - BCD_ZERO=20'h00000.
  - DIGIT_OFF=4'hF.
  - Digit slice positions within the 20-bit word.
- One sub-module, blink_gen: parameter BLINK_COUNT; inputs clk, rst, sync_clr; output phase. Counter width $clog2(BLINK_COUNT).
- The FSM and the time registers stay in race_display_ctrl.

Test Plan:
1. rst, then arm_p, then start_p -> state 1 then 2. cnt_clear 1->0 and cnt_run 0->1 right after the start_p edge. Digits track live_bcd.
2. RUNNING, live=20'h00050, finish_p -> ignored (still RUNNING). Then at live=20'h01234, finish_p -> FINISHED, result and best=0:12.34, new_record=1, digits blink with period 2*BLINK_COUNT (use BLINK_COUNT=4 in sim).
3. Second run finishing at 20'h01234 (equal) -> new_record=0, no blink, best stays 0:12.34. Third run at 20'h01199 -> best=0:11.99, new_record=1.
4. RUNNING with cnt_max=1 and finish_p in the same cycle -> FINISHED, dnf=1, result 9:59.99, best unchanged.
5. RUNNING with clr_p and finish_p in the same cycle -> IDLE, result/best unchanged, cnt_clear=1. clr_p again in IDLE -> digits 0:00.00, best_valid=0.
6. rst asserted in RUNNING -> next cycle IDLE, cnt_run=0, best cleared. Blink counter restarts visible on entry to ARMED.
